// File: rtl/bsram_arb_pkg.sv
// rtl/bsram_arb_pkg.sv - shared types and constants for the BSRAM arbiter
package bsram_arb_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 32;

  // Index width for n requesters; never narrower than one bit.
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsram_arbiter_picker.sv
// rtl/bsram_arbiter_picker.sv - round-robin picker: first valid at or after the pointer
module rr_priority_picker
  import bsram_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = req_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_valid[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/bsram_arbiter.sv
// rtl/bsram_arbiter.sv - round-robin BSRAM arbiter with RMW lock and lock timeout
// BSRAM_ARB_STATS_EN builds per-requester grant/stall counters.
module bsram_arbiter
  import bsram_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int DATA_WIDTH   = 32,
  parameter  int ADDR_WIDTH   = 8,
  parameter  int LOCK_TIMEOUT = 16,
  localparam int IW           = req_idx_w(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           mem_readEnable,
  output logic [ADDR_WIDTH-1:0]          mem_readAddress,
  input  logic [DATA_WIDTH-1:0]          mem_readData,
  output logic                           mem_writeEnable,
  output logic [ADDR_WIDTH-1:0]          mem_writeAddress,
  output logic [DATA_WIDTH-1:0]          mem_writeData,
  input  logic [IW-1:0]                  stat_sel,
  output logic [STAT_WIDTH-1:0]          stat_grants,
  output logic [STAT_WIDTH-1:0]          stat_stalls
);

  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t          r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_lock_owner;
  logic [LW-1:0]       r_lock_idle;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;

  logic [NUM_REQ-1:0]  w_cand;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_wr;
  logic                w_rd;
  logic                w_lock;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [IW-1:0]       w_next_ptr;
  logic [IW-1:0]       w_owner_next;

  // While locked only the owner may compete; nothing is granted during reset.
  always_comb begin
    w_cand = req_valid & {NUM_REQ{reset}};
    if (r_state == ARB_LOCKED)
      w_cand = w_cand & (NUM_REQ'(1) << r_lock_owner);
  end

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_valid (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_addr       = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata      = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_lock       = req_lock[w_idx];
  assign w_wr         = w_any & req_write[w_idx];
  assign w_rd         = w_any & ~req_write[w_idx];
  assign w_next_ptr   = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_owner_next = (r_lock_owner == IW'(NUM_REQ - 1)) ? '0 : r_lock_owner + 1'b1;

  assign req_ready        = w_grant;
  assign mem_readEnable   = w_rd;
  assign mem_readAddress  = w_rd ? w_addr : '0;
  assign mem_writeEnable  = w_wr;
  assign mem_writeAddress = w_wr ? w_addr : '0;
  assign mem_writeData    = w_wr ? w_wdata : '0;
  assign resp_valid       = r_resp_valid;
  assign resp_data        = r_resp_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_OPEN;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      r_lock_idle  <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_grant;
      if (w_any)
        r_resp_data <= w_wr ? w_wdata : mem_readData;
      case (r_state)
        ARB_OPEN: begin
          if (w_any) begin
            r_rr_ptr <= w_next_ptr;
            if (w_lock) begin
              r_state      <= ARB_LOCKED;
              r_lock_owner <= w_idx;
              r_lock_idle  <= '0;
            end
          end
        end
        ARB_LOCKED: begin
          // Any grant here is the owner; no grant means the owner is idle.
          if (w_any) begin
            r_lock_idle <= '0;
            if (!w_lock) begin
              r_state  <= ARB_OPEN;
              r_rr_ptr <= w_owner_next;
            end
          end else if (r_lock_idle == LW'(LOCK_TIMEOUT - 1)) begin
            r_state     <= ARB_OPEN;
            r_rr_ptr    <= w_owner_next;
            r_lock_idle <= '0;
          end else begin
            r_lock_idle <= r_lock_idle + 1'b1;
          end
        end
        default: r_state <= ARB_OPEN;
      endcase
    end
  end

`ifdef BSRAM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_grants [NUM_REQ];
  logic [STAT_WIDTH-1:0] r_stalls [NUM_REQ];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grants[i] <= '0;
        r_stalls[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && (r_grants[i] != '1))
          r_grants[i] <= r_grants[i] + 1'b1;
        if (req_valid[i] && !w_grant[i] && (r_stalls[i] != '1))
          r_stalls[i] <= r_stalls[i] + 1'b1;
      end
    end
  end

  assign stat_grants = (int'(stat_sel) < NUM_REQ) ? r_grants[stat_sel] : '0;
  assign stat_stalls = (int'(stat_sel) < NUM_REQ) ? r_stalls[stat_sel] : '0;
`else
  logic w_stat_unused;
  assign w_stat_unused = ^stat_sel;
  assign stat_grants   = '0;
  assign stat_stalls   = '0;
`endif

endmodule

// File: tb/tb_bsram_arbiter.sv
// tb/tb_bsram_arbiter.sv - vector table plus response scoreboard for bsram_arbiter
module tb_bsram_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_lock, req_ready, resp_valid;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] resp_data, mem_readData, mem_writeData;
  logic        mem_readEnable, mem_writeEnable;
  logic [7:0]  mem_readAddress, mem_writeAddress;
  logic [0:0]  stat_sel;
  logic [31:0] stat_grants, stat_stalls;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [1:0]  v, w, l;
    logic [7:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  er;
  } vec_t;

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] d;
  } sb_t;

  sb_t  sb [$];
  vec_t tbl [19];

  bsram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(8), .LOCK_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress),
    .mem_readData(mem_readData), .mem_writeEnable(mem_writeEnable),
    .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData),
    .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_readData = mem[mem_readAddress];
  always @(posedge clock) if (mem_writeEnable) mem[mem_writeAddress] <= mem_writeData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response scoreboard: check what was owed from the previous cycle, then log this cycle's accepts.
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      chk("resp_in_reset", 32'(resp_valid), 32'h0);
    end else begin
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(e.oh));
        chk("resp_data", resp_data, e.d);
      end else begin
        chk("resp_idle", 32'(resp_valid), 32'h0);
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_t e;
          logic [7:0]  a;
          logic [31:0] d;
          a = req_addr[i*8 +: 8];
          d = req_wdata[i*32 +: 32];
          e.oh = 2'(1 << i);
          e.d  = req_write[i] ? d : ref_mem[a];
          if (req_write[i]) ref_mem[a] = d;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step(input vec_t t, input string nm);
    req_valid = t.v;
    req_write = t.w;
    req_lock  = t.l;
    req_addr  = {t.a1, t.a0};
    req_wdata = {t.d1, t.d0};
    @(negedge clock);
    chk({nm, "_ready"}, 32'(req_ready), 32'(t.er));
    chk({nm, "_ren"}, 32'(mem_readEnable), 32'(|(t.er & ~t.w)));
    chk({nm, "_wen"}, 32'(mem_writeEnable), 32'(|(t.er & t.w)));
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] v, w, l, input logic [7:0] a0, a1,
                              input logic [31:0] d0, d1, input logic [1:0] er);
    vec_t t;
    t.v = v; t.w = w; t.l = l; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.er = er;
    return t;
  endfunction

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]     = {4{8'(k)}} ^ 32'h5A00_0000;
      ref_mem[k] = {4{8'(k)}} ^ 32'h5A00_0000;
    end
    reset = 1'b0; stat_sel = 1'b0;
    req_valid = 2'b11; req_write = 2'b00; req_lock = 2'b00;
    req_addr = 16'h0201; req_wdata = '0;

    tbl[0]  = mk(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 2'b01);
    tbl[1]  = mk(2'b11, 2'b00, 2'b00, 8'h03, 8'h04, 32'h0, 32'h0, 2'b10);
    tbl[2]  = mk(2'b11, 2'b00, 2'b00, 8'h05, 8'h06, 32'h0, 32'h0, 2'b01);
    tbl[3]  = mk(2'b11, 2'b00, 2'b00, 8'h07, 8'h08, 32'h0, 32'h0, 2'b10);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00, 8'h09, 8'h00, 32'h0, 32'h0, 2'b01);
    tbl[5]  = mk(2'b01, 2'b00, 2'b00, 8'h0A, 8'h00, 32'h0, 32'h0, 2'b01);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00);
    tbl[7]  = mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h0B, 32'h0, 32'h0, 2'b10);
    tbl[8]  = mk(2'b11, 2'b00, 2'b01, 8'h10, 8'h10, 32'h0, 32'h0, 2'b01);
    tbl[9]  = mk(2'b10, 2'b00, 2'b00, 8'h10, 8'h10, 32'h0, 32'h0, 2'b00);
    tbl[10] = mk(2'b10, 2'b00, 2'b00, 8'h10, 8'h10, 32'h0, 32'h0, 2'b00);
    tbl[11] = mk(2'b11, 2'b01, 2'b00, 8'h10, 8'h10, 32'hA5A5A5A5, 32'h0, 2'b01);
    tbl[12] = mk(2'b10, 2'b00, 2'b00, 8'h10, 8'h10, 32'h0, 32'h0, 2'b10);
    tbl[13] = mk(2'b01, 2'b01, 2'b00, 8'h20, 8'h00, 32'h12345678, 32'h0, 2'b01);
    tbl[14] = mk(2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0, 2'b01);
    tbl[15] = mk(2'b10, 2'b00, 2'b10, 8'h00, 8'h21, 32'h0, 32'h0, 2'b10);
    tbl[16] = mk(2'b11, 2'b10, 2'b00, 8'h22, 8'h21, 32'h0, 32'hCAFEF00D, 2'b10);
    tbl[17] = mk(2'b11, 2'b00, 2'b00, 8'h21, 8'h22, 32'h0, 32'h0, 2'b01);
    tbl[18] = mk(2'b11, 2'b00, 2'b00, 8'h23, 8'h21, 32'h0, 32'h0, 2'b10);

    // Reset held with requests pending
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ren", 32'(mem_readEnable), 32'h0);
    chk("rst_wen", 32'(mem_writeEnable), 32'h0);
    chk("rst_rdata", resp_data, 32'h0);
    chk("rst_grants", stat_grants, 32'h0);
    chk("rst_stalls", stat_stalls, 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("v%0d", i));

    // Lock timeout: owner req0 goes idle, req1 must wait out 16 idle cycles
    step(mk(2'b01, 2'b00, 2'b01, 8'h30, 8'h31, 32'h0, 32'h0, 2'b01), "to_lock");
    for (int k = 1; k <= 17; k++)
      step(mk(2'b10, 2'b00, 2'b00, 8'h30, 8'h31, 32'h0, 32'h0, (k == 17) ? 2'b10 : 2'b00),
           $sformatf("to_idle%0d", k));
    step(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00), "to_done");

    // Reset during an outstanding read; earlier write must survive
    step(mk(2'b01, 2'b01, 2'b00, 8'h30, 8'h00, 32'hDEADBEEF, 32'h0, 2'b01), "rm_wr");
    step(mk(2'b01, 2'b00, 2'b00, 8'h30, 8'h00, 32'h0, 32'h0, 2'b01), "rm_rd");
    reset = 1'b0;
    req_valid = 2'b00;
    @(negedge clock);
    chk("rm_resp_dropped", 32'(resp_valid), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    step(mk(2'b01, 2'b00, 2'b00, 8'h30, 8'h00, 32'h0, 32'h0, 2'b01), "rm_reread");

    // Stats: req1 stalls 3 cycles behind a lock, then gets 2 grants
    step(mk(2'b01, 2'b00, 2'b01, 8'h40, 8'h41, 32'h0, 32'h0, 2'b01), "st_lock");
    step(mk(2'b11, 2'b00, 2'b01, 8'h40, 8'h41, 32'h0, 32'h0, 2'b01), "st_hold1");
    step(mk(2'b11, 2'b00, 2'b01, 8'h40, 8'h41, 32'h0, 32'h0, 2'b01), "st_hold2");
    step(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h41, 32'h11112222, 32'h0, 2'b01), "st_rel");
    step(mk(2'b10, 2'b00, 2'b00, 8'h40, 8'h41, 32'h0, 32'h0, 2'b10), "st_g1");
    step(mk(2'b10, 2'b00, 2'b00, 8'h40, 8'h42, 32'h0, 32'h0, 2'b10), "st_g2");
    req_valid = 2'b00;
    stat_sel = 1'b1;
    #1;
`ifdef BSRAM_ARB_STATS_EN
    chk("st1_grants", stat_grants, 32'd2);
    chk("st1_stalls", stat_stalls, 32'd3);
    stat_sel = 1'b0;
    #1;
    chk("st0_grants", stat_grants, 32'd5);
    chk("st0_stalls", stat_stalls, 32'd0);
`else
    chk("st1_grants", stat_grants, 32'd0);
    chk("st1_stalls", stat_stalls, 32'd0);
    stat_sel = 1'b0;
    #1;
    chk("st0_grants", stat_grants, 32'd0);
    chk("st0_stalls", stat_stalls, 32'd0);
`endif
    @(posedge clock);
    @(negedge clock);
    chk("final_resp", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
